// File: rtl/multi_channel_timer.sv
// Bank of independent programmable down-count timers (one-shot or periodic)
// plus a global free-running cycle counter with a wrap pulse.
module multi_channel_timer #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CYC_WIDTH = 32,
  parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_chan,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_mode,
  input  logic [CHANNELS-1:0]  start,
  input  logic [CHANNELS-1:0]  stop,
  input  logic [CH_W-1:0]      rd_chan,
  output logic [WIDTH-1:0]     rd_count,
  output logic                 rd_running,
  output logic [CHANNELS-1:0]  running,
  output logic [CHANNELS-1:0]  expired,
  output logic [CYC_WIDTH-1:0] cycle_count,
  output logic                 cycle_wrap
);

  logic [WIDTH-1:0]     count_all [CHANNELS];
  logic [CHANNELS-1:0]  running_all;
  logic [CHANNELS-1:0]  expired_all;
  logic [CYC_WIDTH-1:0] cycle_count_reg;
  logic                 cycle_wrap_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] reload_reg;
      logic [WIDTH-1:0] count_reg;
      logic             mode_reg;
      logic             running_reg;
      logic             expired_reg;
      logic             load_hit;

      // Out-of-range wr_chan values match no channel and are dropped.
      assign load_hit = wr_en && (wr_chan == CH_W'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          reload_reg  <= '0;
          count_reg   <= '0;
          mode_reg    <= 1'b0;
          running_reg <= 1'b0;
          expired_reg <= 1'b0;
        end else if (load_hit) begin
          reload_reg  <= wr_data;
          count_reg   <= wr_data;
          mode_reg    <= wr_mode;
          running_reg <= 1'b0;
          expired_reg <= 1'b0;
        end else if (stop[gi]) begin
          running_reg <= 1'b0;
          expired_reg <= 1'b0;
        end else if (running_reg) begin
          // Start requests are ignored while running; only counting happens.
          if (count_reg == WIDTH'(1)) begin
            expired_reg <= 1'b1;
            if (mode_reg) begin
              count_reg <= reload_reg;
            end else begin
              count_reg   <= '0;
              running_reg <= 1'b0;
            end
          end else begin
            count_reg   <= count_reg - WIDTH'(1);
            expired_reg <= 1'b0;
          end
        end else if (start[gi] && (reload_reg != '0)) begin
          count_reg   <= reload_reg;
          running_reg <= 1'b1;
          expired_reg <= 1'b0;
        end else begin
          expired_reg <= 1'b0;
        end
      end

      assign count_all[gi]   = count_reg;
      assign running_all[gi] = running_reg;
      assign expired_all[gi] = expired_reg;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_count_reg <= '0;
      cycle_wrap_reg  <= 1'b0;
    end else begin
      cycle_count_reg <= cycle_count_reg + CYC_WIDTH'(1);
      cycle_wrap_reg  <= (cycle_count_reg == {CYC_WIDTH{1'b1}});
    end
  end

  // Compare-based select keeps non-power-of-two channel counts in range.
  always_comb begin
    rd_count   = '0;
    rd_running = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_chan == CH_W'(i)) begin
        rd_count   = count_all[i];
        rd_running = running_all[i];
      end
    end
  end

  assign running     = running_all;
  assign expired     = expired_all;
  assign cycle_count = cycle_count_reg;
  assign cycle_wrap  = cycle_wrap_reg;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed self-checking bench for multi_channel_timer (4 channels, 4-bit cycle counter).
module tb_multi_channel_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_chan = '0;
  logic [15:0] wr_data = '0;
  logic        wr_mode = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  stop = '0;
  logic [1:0]  rd_chan = '0;
  logic [15:0] rd_count;
  logic        rd_running;
  logic [3:0]  running;
  logic [3:0]  expired;
  logic [3:0]  cycle_count;
  logic        cycle_wrap;

  int n_pass  = 0;
  int n_total = 0;

  multi_channel_timer #(
    .WIDTH(16), .CHANNELS(4), .CYC_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data), .wr_mode(wr_mode),
    .start(start), .stop(stop), .rd_chan(rd_chan),
    .rd_count(rd_count), .rd_running(rd_running),
    .running(running), .expired(expired),
    .cycle_count(cycle_count), .cycle_wrap(cycle_wrap)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic load(input logic [1:0] ch, input logic [15:0] data, input logic mode);
    wr_en = 1'b1; wr_chan = ch; wr_data = data; wr_mode = mode;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_running", running, 0);
    chk("rst_expired", expired, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_cycle_wrap", cycle_wrap, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_rd_running", rd_running, 0);
    reset = 1'b0;
    repeat (10) step();
    chk("idle_cycle_count", cycle_count, 10);

    // Channel 0 one-shot, R = 5
    rd_chan = 2'd0;
    load(2'd0, 16'd5, 1'b0);
    chk("os_load_count", rd_count, 5);
    chk("os_load_running", running[0], 0);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("os_start_running", running[0], 1);
    chk("os_start_count", rd_count, 5);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("os_count", rd_count, 32'(5 - j));
      chk("os_no_exp", expired, 0);
    end
    step();
    chk("os_expired", expired, 4'b0001);
    chk("os_done_running", running[0], 0);
    chk("os_done_count", rd_count, 0);
    step();
    chk("os_pulse_end", expired, 0);
    $display("one-shot ch0 R=5 done");

    // Channel 2 periodic, R = 3
    rd_chan = 2'd2;
    load(2'd2, 16'd3, 1'b1);
    start[2] = 1'b1; step(); start[2] = 1'b0;
    chk("per_start_count", rd_count, 3);
    for (int j = 1; j <= 9; j++) begin
      step();
      chk("per_expired", expired, (j % 3 == 0) ? 4'b0100 : 4'b0000);
      chk("per_count", rd_count, (j % 3 == 0) ? 32'd3 : 32'(3 - (j % 3)));
      chk("per_running", running[2], 1);
    end
    stop[2] = 1'b1; step(); stop[2] = 1'b0;
    chk("per_stop_running", running[2], 0);
    chk("per_stop_count", rd_count, 3);
    $display("periodic ch2 R=3 done");

    // Channel 1 R = 8, stop mid-count
    rd_chan = 2'd1;
    load(2'd1, 16'd8, 1'b0);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    chk("stp_start_count", rd_count, 8);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("stp_count", rd_count, 32'(8 - j));
    end
    stop[1] = 1'b1; step(); stop[1] = 1'b0;
    chk("stp_running", running[1], 0);
    chk("stp_hold", rd_count, 4);
    repeat (8) step();
    chk("stp_no_exp", expired, 0);
    chk("stp_still_hold", rd_count, 4);
    stop[1] = 1'b1; start[1] = 1'b1; step(); stop[1] = 1'b0; start[1] = 1'b0;
    chk("stp_start_both", running[1], 0);
    chk("stp_start_both_cnt", rd_count, 4);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    chk("restart_running", rd_running, 1);
    chk("restart_count", rd_count, 8);
    step(); step();
    start[1] = 1'b1; step(); start[1] = 1'b0;
    chk("start_while_run", rd_count, 5);
    stop[1] = 1'b1; step(); stop[1] = 1'b0;
    $display("stop/start ch1 done");

    // R = 0 start ignored
    rd_chan = 2'd3;
    load(2'd3, 16'd0, 1'b0);
    start[3] = 1'b1; step(); start[3] = 1'b0;
    chk("r0_running", running[3], 0);
    chk("r0_rd_running", rd_running, 0);
    chk("r0_count", rd_count, 0);

    // Load periodic ch2 on its C == 1 edge; concurrent load to ch3 while ch2 counts
    rd_chan = 2'd2;
    start[2] = 1'b1; step(); start[2] = 1'b0;
    wr_en = 1'b1; wr_chan = 2'd3; wr_data = 16'd9; wr_mode = 1'b0;
    step();
    wr_en = 1'b0;
    chk("conc_ch2_count", rd_count, 2);
    step();
    chk("c1_count", rd_count, 1);
    rd_chan = 2'd3; #1;
    chk("conc_ch3_count", rd_count, 9);
    rd_chan = 2'd2; #1;
    load(2'd2, 16'd7, 1'b1);
    chk("c1_load_expired", expired, 0);
    chk("c1_load_count", rd_count, 7);
    chk("c1_load_running", running[2], 0);
    step();
    chk("c1_load_no_late", expired, 0);
    $display("load on C==1 done");

    // Async reset mid-count, then counter wrap
    start[2] = 1'b1; step(); start[2] = 1'b0;
    step(); step();
    #3 reset = 1'b1;
    #1;
    chk("arst_running", running, 0);
    chk("arst_expired", expired, 0);
    chk("arst_cycle_count", cycle_count, 0);
    chk("arst_count", rd_count, 0);
    step();
    chk("arst_hold_expired", expired, 0);
    reset = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      chk("wrap_count", cycle_count, 32'(j % 16));
      chk("wrap_pulse", cycle_wrap, (j == 16) ? 1 : 0);
      chk("wrap_no_exp", expired, 0);
    end
    step();
    chk("wrap_pulse_end", cycle_wrap, 0);
    chk("wrap_after", cycle_count, 1);
    $display("reset and wrap done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_channel_timer.md
# multi_channel_timer

Parametrised successor to the single free-running clock counter in the synchronizer work: a synthesizable block holding CHANNELS independent programmable down-count timers plus a global free-running cycle counter. Each channel is loaded with a period and runs as one-shot or periodic, emitting a one-cycle expiry pulse. The block provides cycle-accurate delays and time-outs to the synchronizer datapath. The global counter replaces ad-hoc clock counting in benches.

## Interface

Parameters:
- WIDTH, 16: channel reload/count width in bits (>= 2).
- CHANNELS, 4: number of timer channels (1..16).
- CYC_WIDTH, 32: global cycle counter width.
- CH_W, $clog2(CHANNELS) with a minimum of 1: channel index width.

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- wr_en, in, 1: load strobe.
- wr_chan, in, CH_W: channel addressed by the load.
- wr_data, in, WIDTH: reload value R.
- wr_mode, in, 1: 0 = one-shot, 1 = periodic.
- start, in, CHANNELS: per-channel start request, level-sampled each edge.
- stop, in, CHANNELS: per-channel stop request.
- rd_chan, in, CH_W: readout select.
- rd_count, out, WIDTH: combinational readout of the current count C[rd_chan].
- rd_running, out, 1: combinational readout of the running flag of rd_chan.
- running, out, CHANNELS: registered running flags.
- expired, out, CHANNELS: registered one-cycle expiry pulses.
- cycle_count, out, CYC_WIDTH: free-running clock count.
- cycle_wrap, out, 1: one-cycle pulse when cycle_count wraps.

## Operation

- Per-channel state: reload register R, count C, mode M, running flag.
- Load (wr_en):
  - Sets R = wr_data, M = wr_mode, C = wr_data for wr_chan.
  - Forces that channel's running flag to 0 and its expired output to 0.
  - A wr_chan value >= CHANNELS is ignored.
- Start (start[i] = 1 while not running):
  - If R != 0: C = R, running = 1.
  - If R == 0: the request is ignored.
  - Start while already running is ignored; use stop then start to restart.
- Stop (stop[i] = 1): running = 0 and C holds its value; expired[i] = 0.
- Count (running):
  - If C > 1: C decrements by 1.
  - If C == 1: expired[i] = 1 for one cycle. In periodic mode C = R and the channel keeps running. In one-shot mode C = 0 and running = 0.
- Priority per channel, highest first: reset, load to this channel, stop, start, count. When stop and start arrive together, stop wins.
- Channels are fully independent. Each channel can act on the same edge as a load to a different channel.
- Global counter: cycle_count increments every edge and wraps from all-ones to 0. The edge that produces 0 sets cycle_wrap = 1 for that one cycle.
- Arithmetic is unsigned modulo 2^WIDTH. R = 1 gives an expiry every cycle in periodic mode.

## Timing

- Reset values: running = 0, expired = 0, cycle_count = 0, cycle_wrap = 0, all R, C and M = 0. Therefore rd_count = 0 and rd_running = 0.
- Reset asserted mid-count clears the channel immediately and asynchronously. No expiry pulse appears during or after reset.
- Start latency: with start sampled at edge k, running = 1 and C = R after edge k.
- Expiry timing: expired rises after edge k+R and falls after edge k+R+1.
- Periodic mode: pulses repeat every R cycles, at k+R, k+2R, and so on.
- Load, stop and readout changes are visible one edge after sampling. rd_count and rd_running respond combinationally to rd_chan.
- A stop that coincides with the C == 1 edge suppresses that expiry.
- A load to a channel on its C == 1 edge also suppresses that expiry.

## Test plan

- Reset, then idle for 10 cycles:
  - Required: all outputs 0 during reset.
  - Required: cycle_count = 10 after 10 edges.
- Load channel 0 with R = 5 in one-shot mode, then start at edge k:
  - Required: a single expired[0] pulse after edge k+5.
  - Required: running[0] = 0 and rd_count = 0 afterwards.
- Load channel 2 with R = 3 in periodic mode and start:
  - Required: expired[2] pulses after edges k+3, k+6 and k+9.
  - Required: rd_count cycles through 3, 2, 1, 3.
- Load channel 1 with R = 8, start, then stop at edge k+4:
  - Required: C holds at 4 and there is no expiry.
  - Assert stop and start together: running stays 0.
- Load R = 0 then start:
  - Required: the start is ignored.
  - Also load a periodic channel on its C == 1 edge: the pulse is suppressed, and C equals the new wr_data.
- Set CYC_WIDTH = 4 and run 16 edges:
  - Required: cycle_count wraps to 0 with a single cycle_wrap pulse.
  - Assert reset mid-run on a periodic channel: it clears with no expiry.
